perlane_scrambler_ctrl: RTL



---
 rtl/perlane_scrambler_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/perlane_scrambler_ctrl.sv
// -----------------------------------------------------------------------------
// perlane_scrambler_ctrl
//
// Sequencing/scheduling controller in front of a per-lane 256-bit scrambler.
// Brings the scrambler up from disabled through an idle-word LFSR flush, then
// streams upstream words (valid/ready) into the scrambler, filling gaps with
// IDLE_WORD and inserting an alignment-marker slot every AM_PERIOD words.
//
// Ports:
//   clk              single clock
//   reset            asynchronous, active-high reset
//   cfg_enable       lane enable level
//   up_data/up_valid upstream word and its valid
//   up_ready         word accepted when up_valid & up_ready
//   scr_enable       scrambler in_enable
//   scr_txdata       scrambler in_txdata (registered)
//   scr_txdata_valid scrambler in_txdata_valid
//   scr_idle         current output word is IDLE_WORD
//   am_slot          current output word is an alignment-marker slot
//   state_run        controller is in RUN
//   am_count         position in the AM period of the word being prepared
//
// Timing model: all scr_* / am_slot outputs are registered. During a RUN cycle
// the controller prepares the word for the next cycle; am_count is the period
// position of that word, so am_count==AM_PERIOD-1 in the cycle just before
// am_slot is seen high.
// -----------------------------------------------------------------------------
module perlane_scrambler_ctrl #(
    parameter int           WARMUP_CYCLES = 16,
    parameter int           AM_PERIOD     = 1024,
    parameter logic [255:0] IDLE_WORD     = {32{8'h1E}},
    parameter logic [255:0] AM_WORD       = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_enable,
    input  logic [255:0] up_data,
    input  logic         up_valid,
    output logic         up_ready,
    output logic         scr_enable,
    output logic [255:0] scr_txdata,
    output logic         scr_txdata_valid,
    output logic         scr_idle,
    output logic         am_slot,
    output logic         state_run,
    output logic [15:0]  am_count
);

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    localparam logic [7:0]  WARM_LAST = 8'(WARMUP_CYCLES - 1);
    localparam logic [15:0] AM_LAST   = 16'(AM_PERIOD - 1);

    logic [1:0]   state_q, state_d;
    logic [7:0]   warm_cnt_q, warm_cnt_d;
    logic [15:0]  am_count_q, am_count_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   fill_q, fill_d;
    logic         scr_enable_q, scr_enable_d;
    logic [255:0] scr_txdata_q, scr_txdata_d;
    logic         scr_txdata_valid_q, scr_txdata_valid_d;
    logic         scr_idle_q, scr_idle_d;
    logic         am_slot_q, am_slot_d;

    logic [255:0] buf_mem [2];

    logic run_active;
    logic am_prep;
    logic pop_slot;
    logic ready_int;
    logic push;
    logic take_fifo;
    logic bypass;
    logic store;

    // A pop opportunity exists on every enabled RUN cycle that is not
    // preparing the marker slot. When the skid buffer is empty, an accepted
    // word goes straight to the output register so latency stays one cycle.
    assign run_active = (state_q == ST_RUN) && cfg_enable;
    assign am_prep    = (am_count_q == AM_LAST);
    assign pop_slot   = run_active && !am_prep;
    assign ready_int  = run_active && ((fill_q != 2'd2) || pop_slot);
    assign push       = up_valid && ready_int;
    assign take_fifo  = pop_slot && (fill_q != 2'd0);
    assign bypass     = pop_slot && (fill_q == 2'd0) && push;
    assign store      = push && !bypass;

    always_comb begin
        state_d            = state_q;
        warm_cnt_d         = warm_cnt_q;
        am_count_d         = '0;
        scr_enable_d       = 1'b0;
        scr_txdata_d       = '0;
        scr_txdata_valid_d = 1'b0;
        scr_idle_d         = 1'b0;
        am_slot_d          = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (cfg_enable) begin
                    state_d      = ST_WARMUP;
                    warm_cnt_d   = '0;
                    scr_enable_d = 1'b1;
                end
            end
            ST_WARMUP: begin
                if (!cfg_enable) begin
                    state_d = ST_OFF;
                end else begin
                    scr_enable_d       = 1'b1;
                    scr_txdata_valid_d = 1'b1;
                    scr_idle_d         = 1'b1;
                    scr_txdata_d       = IDLE_WORD;
                    warm_cnt_d         = warm_cnt_q + 8'd1;
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!cfg_enable) begin
                    state_d = ST_OFF;
                end else begin
                    scr_enable_d       = 1'b1;
                    scr_txdata_valid_d = 1'b1;
                    am_count_d         = am_prep ? 16'd0 : am_count_q + 16'd1;
                    if (am_prep) begin
                        scr_txdata_d = AM_WORD;
                        am_slot_d    = 1'b1;
                    end else if (take_fifo) begin
                        scr_txdata_d = buf_mem[rd_ptr_q];
                    end else if (bypass) begin
                        scr_txdata_d = up_data;
                    end else begin
                        scr_txdata_d = IDLE_WORD;
                        scr_idle_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Skid buffer bookkeeping; anything outside an enabled RUN cycle flushes it.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (!run_active) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            fill_d   = 2'd0;
        end else begin
            if (take_fifo) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (store) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            fill_d = fill_q + {1'b0, store} - {1'b0, take_fifo};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= ST_OFF;
            warm_cnt_q         <= '0;
            am_count_q         <= '0;
            rd_ptr_q           <= 1'b0;
            wr_ptr_q           <= 1'b0;
            fill_q             <= 2'd0;
            scr_enable_q       <= 1'b0;
            scr_txdata_q       <= '0;
            scr_txdata_valid_q <= 1'b0;
            scr_idle_q         <= 1'b0;
            am_slot_q          <= 1'b0;
        end else begin
            state_q            <= state_d;
            warm_cnt_q         <= warm_cnt_d;
            am_count_q         <= am_count_d;
            rd_ptr_q           <= rd_ptr_d;
            wr_ptr_q           <= wr_ptr_d;
            fill_q             <= fill_d;
            scr_enable_q       <= scr_enable_d;
            scr_txdata_q       <= scr_txdata_d;
            scr_txdata_valid_q <= scr_txdata_valid_d;
            scr_idle_q         <= scr_idle_d;
            am_slot_q          <= am_slot_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by fill_q and the pointers.
    always_ff @(posedge clk) begin
        if (store) begin
            buf_mem[wr_ptr_q] <= up_data;
        end
    end

    assign up_ready         = ready_int;
    assign scr_enable       = scr_enable_q;
    assign scr_txdata       = scr_txdata_q;
    assign scr_txdata_valid = scr_txdata_valid_q;
    assign scr_idle         = scr_idle_q;
    assign am_slot          = am_slot_q;
    assign state_run        = (state_q == ST_RUN);
    assign am_count         = am_count_q;

endmodule
